// File: rtl/scan_ctl_pkg.sv
// rtl/scan_ctl_pkg.sv - shared state encoding and sizing helpers for the scan chain controller
package scan_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } scan_state_e;

  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_ctl_shreg.sv
// rtl/scan_ctl_shreg.sv - chain-wide register with parallel load, MSB-first shift and indexed bit write
module scan_ctl_shreg #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [CHAIN_LEN-1:0]         load_data,
  input  logic                         shift,
  input  logic                         wr_en,
  input  logic [$clog2(CHAIN_LEN)-1:0] wr_idx,
  input  logic                         wr_bit,
  output logic [CHAIN_LEN-1:0]         q
);

  // Shifting fills with zero, so a fully shifted-out register reads as all zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[CHAIN_LEN-2:0], 1'b0};
    end else if (wr_en) begin
      q[wr_idx] <= wr_bit;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl.sv - load/capture/unload sequencer for an sdffq scan chain
module gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl
  import scan_ctl_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic [CHAIN_LEN-1:0] EXPECT,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] CAPTURED,
  output logic                 FAIL
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam int IW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CHAIN_LEN);

  scan_state_e          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;
  logic                 se_q, se_nxt, fail_q;
  logic [CHAIN_LEN-1:0] expect_q, pat_q, cap_q;
  logic                 accept, pat_shift, cap_wr, cnt_last;
  logic [IW-1:0]        cap_idx;

  assign cnt_last = (cnt == CNT_LAST);
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  // The j-th unload edge (cnt = j-1) carries chain bit CHAIN_LEN-j.
  assign cap_idx  = IW'(CHAIN_LEN - 1 - int'(cnt));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    se_nxt    = 1'b0;
    accept    = 1'b0;
    pat_shift = 1'b0;
    cap_wr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT_IN;
          cnt_nxt   = '0;
          se_nxt    = 1'b1;
        end
      end
      ST_SHIFT_IN: begin
        pat_shift = 1'b1;
        if (cnt_last) begin
          state_nxt = ST_CAPTURE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          se_nxt  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_SHIFT_OUT;
        cnt_nxt   = '0;
        se_nxt    = 1'b1;
      end
      ST_SHIFT_OUT: begin
        cap_wr = 1'b1;
        if (cnt_last) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          se_nxt  = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      se_q     <= 1'b0;
      fail_q   <= 1'b0;
      expect_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      se_q  <= se_nxt;
      if (accept) expect_q <= EXPECT;
      // Bit 0 arrives on the same edge, so compare against the merged value.
      if (cap_wr && cnt_last) fail_q <= ({cap_q[CHAIN_LEN-1:1], SO} != expect_q);
    end
  end

  scan_ctl_shreg #(.CHAIN_LEN(CHAIN_LEN)) u_pat_shreg (
    .clk       (CLK),
    .rst       (RST),
    .load      (accept),
    .load_data (PATTERN),
    .shift     (pat_shift),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_bit    (1'b0),
    .q         (pat_q)
  );

  scan_ctl_shreg #(.CHAIN_LEN(CHAIN_LEN)) u_cap_shreg (
    .clk       (CLK),
    .rst       (RST),
    .load      (accept),
    .load_data ('0),
    .shift     (1'b0),
    .wr_en     (cap_wr),
    .wr_idx    (cap_idx),
    .wr_bit    (SO),
    .q         (cap_q)
  );

  // SI is the pattern register's MSB flop; after CHAIN_LEN shifts it has drained to zero.
  always_comb begin
    if (state == ST_CAPTURE) assert (pat_q == '0);
  end

  assign SE       = se_q;
  assign SI       = pat_q[CHAIN_LEN-1];
  assign BUSY     = (state != ST_IDLE);
  assign DONE     = (state == ST_DONE);
  assign CAPTURED = cap_q;
  assign FAIL     = fail_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl.sv - self-checking bench with behavioural sdffq chains
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl;

  logic       clk = 1'b0;
  logic       rst, start, start_w;
  logic [3:0] pattern, expct, captured, chain, dconst;
  logic       so, se, si, busy, done, fail, dmode;
  logic [1:0] pat2, cap2, ch2;
  logic       so2, se2, si2, busy2, done2, fail2;
  logic [16:0] pat17, cap17, ch17;
  logic       so17, se17, si17, busy17, done17, fail17;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl #(.CHAIN_LEN(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .PATTERN(pattern), .EXPECT(expct), .SO(so),
    .SE(se), .SI(si), .BUSY(busy), .DONE(done), .CAPTURED(captured), .FAIL(fail)
  );
  gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl #(.CHAIN_LEN(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start_w), .PATTERN(pat2), .EXPECT(pat2), .SO(so2),
    .SE(se2), .SI(si2), .BUSY(busy2), .DONE(done2), .CAPTURED(cap2), .FAIL(fail2)
  );
  gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctl #(.CHAIN_LEN(17)) dut17 (
    .CLK(clk), .RST(rst), .START(start_w), .PATTERN(pat17), .EXPECT(pat17), .SO(so17),
    .SE(se17), .SI(si17), .BUSY(busy17), .DONE(done17), .CAPTURED(cap17), .FAIL(fail17)
  );

  // sdffq chains: SE selects scan shift, otherwise D (own Q, or a fixed vector for the 4-bit chain).
  always @(posedge clk) chain <= se ? {chain[2:0], si} : (dmode ? dconst : chain);
  always @(posedge clk) ch2   <= se2 ? {ch2[0], si2} : ch2;
  always @(posedge clk) ch17  <= se17 ? {ch17[15:0], si17} : ch17;
  assign so   = chain[3];
  assign so2  = ch2[1];
  assign so17 = ch17[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full sequence on the 4-bit DUT; START is re-driven each cycle from pulse_mask.
  task automatic run_one(input string name, input logic [3:0] p, input logic [3:0] e,
                         input bit dm, input logic [3:0] dc, input logic [3:0] xcap,
                         input bit xfail, input logic [15:0] pulse_mask);
    int edges, busy_cnt, done_cnt;
    logic [3:0] si_obs;
    logic [9:0] se_obs, xse;
    @(negedge clk);
    pattern = p; expct = e; dmode = dm; dconst = dc; start = 1'b1;
    @(posedge clk);
    edges = 0; busy_cnt = 0; done_cnt = 0; si_obs = '0; se_obs = '0;
    while (edges < 40) begin
      @(negedge clk);
      start = (edges < 15) ? pulse_mask[edges+1] : 1'b0;
      if (edges == 0) begin
        pattern = 4'($urandom);
        expct   = 4'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (edges < 10) se_obs[edges] = se;
      if (edges < 4) si_obs[3-edges] = si;
      if (done) break;
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) xse[i] = !(i == 4 || i == 9);
    chk({name, "_latency"}, 32'(edges), 32'd9);
    chk({name, "_captured"}, 32'(captured), 32'(xcap));
    chk({name, "_fail"}, 32'(fail), 32'(xfail));
    chk({name, "_si_seq"}, 32'(si_obs), 32'(p));
    chk({name, "_se_seq"}, 32'(se_obs), 32'(xse));
    repeat (3) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd10);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  // Walking-one on the 2- and 17-flop chains started together.
  task automatic run_w(input int i2, input int i17);
    int edges, l2, l17;
    @(negedge clk);
    pat2 = 2'(1 << i2); pat17 = 17'(1 << i17); start_w = 1'b1;
    @(posedge clk);
    edges = 0; l2 = -1; l17 = -1;
    while (edges < 60) begin
      @(negedge clk);
      start_w = 1'b0;
      if (done2 && l2 < 0) begin
        l2 = edges;
        chk("w2_captured", 32'(cap2), 32'(pat2));
        chk("w2_fail", 32'(fail2), 32'd0);
      end
      if (done17 && l17 < 0) begin
        l17 = edges;
        chk("w17_captured", 32'(cap17), 32'(pat17));
        chk("w17_fail", 32'(fail17), 32'd0);
      end
      if (l2 >= 0 && l17 >= 0) break;
      @(posedge clk);
      edges++;
    end
    chk("w2_latency", 32'(l2), 32'd5);
    chk("w17_latency", 32'(l17), 32'd35);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] p;
    logic [3:0] e;
    bit         dm;
    logic [3:0] dc;
    logic [3:0] cap;
    bit         f;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int edges, first, second, idle_cnt;
    logic [3:0] si_obs, rp, re, rdc, rcap;
    bit rdm;

    tbl[0] = '{4'b1011, 4'b1011, 1'b0, 4'b0000, 4'b1011, 1'b0};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1, 4'b0110, 4'b0110, 1'b1};
    tbl[2] = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[3] = '{4'b0101, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b0};

    rst = 1'b1; start = 1'b0; start_w = 1'b0; pattern = '0; expct = '0;
    dmode = 1'b0; dconst = '0; pat2 = '0; pat17 = '0;
    repeat (2) @(negedge clk);
    chk("rst_se", 32'(se), 32'd0);
    chk("rst_si", 32'(si), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_captured", 32'(captured), 32'd0);
    chk("rst_busy17", 32'(busy17), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].p, tbl[i].e, tbl[i].dm, tbl[i].dc,
              tbl[i].cap, tbl[i].f, 16'h0000);

    run_one("busy_ignore", 4'b0101, 4'b0101, 1'b0, 4'b0000, 4'b0101, 1'b0, 16'h0044);

    // Reset asserted between clock edges during the second SHIFT_OUT cycle.
    @(negedge clk);
    pattern = 4'b1001; expct = 4'b1001; dmode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midop_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midop_se", 32'(se), 32'd0);
    chk("midop_busy", 32'(busy), 32'd0);
    chk("midop_captured", 32'(captured), 32'd0);
    chk("midop_si", 32'(si), 32'd0);
    chk("midop_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one("post_reset", 4'b0110, 4'b0110, 1'b0, 4'b0000, 4'b0110, 1'b0, 16'h0000);

    // START held high; PATTERN/EXPECT change right after the first accepting edge.
    @(negedge clk);
    pattern = 4'hA; expct = 4'hA; dmode = 1'b0; start = 1'b1;
    @(posedge clk);
    edges = 0; first = -1; second = -1; idle_cnt = 0; si_obs = '0;
    while (edges < 60) begin
      @(negedge clk);
      if (edges == 0) begin
        pattern = 4'h5;
        expct   = 4'h5;
      end
      if (edges < 4) si_obs[3-edges] = si;
      if (first >= 0 && !busy) idle_cnt++;
      if (done) begin
        if (first < 0) begin
          first = edges;
          chk("b2b_cap1", 32'(captured), 32'hA);
          chk("b2b_fail1", 32'(fail), 32'd0);
        end else begin
          second = edges;
          chk("b2b_cap2", 32'(captured), 32'h5);
          chk("b2b_fail2", 32'(fail), 32'd0);
          break;
        end
      end
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    chk("b2b_si_seq", 32'(si_obs), 32'hA);
    chk("b2b_first", 32'(first), 32'd9);
    chk("b2b_second", 32'(second), 32'd20);
    chk("b2b_idle_cycles", 32'(idle_cnt), 32'd1);

    run_w(0, 0);
    run_w(1, 16);
    run_w(0, 8);
    for (int k = 0; k < 4; k++) run_w($urandom_range(0, 1), $urandom_range(0, 16));

    // Random vectors against the chain-level model: capture is the pattern (D=Q) or the D vector.
    for (int k = 0; k < 16; k++) begin
      rp   = 4'($urandom);
      rdm  = 1'($urandom);
      rdc  = 4'($urandom);
      rcap = rdm ? rdc : rp;
      re   = ($urandom_range(0, 1) == 1) ? rcap : 4'($urandom);
      run_one($sformatf("rand%0d", k), rp, re, rdm, rdc, rcap, (rcap != re), 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
